// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter
// Shares one device register bus between two requesters. Port 0 is the
// AXI4-Lite register bridge and port 1 is the local sensor/LCD init sequencer.
// The arbiter runs one register transaction at a time. It issues a single-cycle
// write or read strobe on the device bus, then returns a one-cycle response
// pulse to the port that won.
//
// Parameters
//   RD_LAT     : cycles from the dev_rvalid_o strobe to valid dev_rdata_i (1..15)
//   FIXED_PRIO : 0 = round-robin on contention, 1 = port 0 always wins
//
// Ports
//   clk_i, rst_n_i             : clock, synchronous active-low reset
//   pN_req_valid_i/ready_o     : request handshake (ready only in IDLE, for the granted port)
//   pN_req_wr_i/index_i/cmd_i/wdata_i/be_i : request fields, sampled at accept
//   pN_rsp_valid_o/rsp_rdata_o : one-cycle response pulse; rdata is 0 for writes
//                                and holds until the next response on that port
//   dev_index_o/cmd_o/wdata_o/wvalid_be_o  : registered device bus fields
//   dev_wvalid_o/dev_rvalid_o  : one-cycle write/read strobes
//   dev_rdata_i                : device read data, valid RD_LAT cycles after the read strobe
//   busy_o                     : high whenever a transaction is in progress
module reg_bus_arbiter #(
  parameter int RD_LAT     = 2,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,

  input  logic        p0_req_valid_i,
  output logic        p0_req_ready_o,
  input  logic        p0_req_wr_i,
  input  logic [7:0]  p0_req_index_i,
  input  logic [7:0]  p0_req_cmd_i,
  input  logic [31:0] p0_req_wdata_i,
  input  logic [3:0]  p0_req_be_i,
  output logic        p0_rsp_valid_o,
  output logic [31:0] p0_rsp_rdata_o,

  input  logic        p1_req_valid_i,
  output logic        p1_req_ready_o,
  input  logic        p1_req_wr_i,
  input  logic [7:0]  p1_req_index_i,
  input  logic [7:0]  p1_req_cmd_i,
  input  logic [31:0] p1_req_wdata_i,
  input  logic [3:0]  p1_req_be_i,
  output logic        p1_rsp_valid_o,
  output logic [31:0] p1_rsp_rdata_o,

  output logic [7:0]  dev_index_o,
  output logic [7:0]  dev_cmd_o,
  output logic [31:0] dev_wdata_o,
  output logic [3:0]  dev_wvalid_be_o,
  output logic        dev_wvalid_o,
  output logic        dev_rvalid_o,
  input  logic [31:0] dev_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;

  // The read wait counter starts at RD_LAT-1 in the cycle after the strobe.
  // It reaches zero exactly in the cycle strobe+RD_LAT, which is the cycle
  // in which dev_rdata_i is sampled.
  localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

  state_t      state;
  logic        rr_last;
  logic        gnt_q;
  logic        wr_q;
  logic [3:0]  cnt;

  logic        any_req;
  logic        gnt;
  logic        accept;
  logic        sel_wr;
  logic [7:0]  sel_index;
  logic [7:0]  sel_cmd;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_be;
  logic        rsp_fire;
  logic [31:0] rsp_data;

  always_comb begin
    any_req = p0_req_valid_i | p1_req_valid_i;
    // On contention the winner is the port that did not win last time, or
    // port 0 under fixed priority. With one requester, that requester wins.
    if (p0_req_valid_i && p1_req_valid_i) begin
      gnt = FIXED_PRIO ? 1'b0 : ~rr_last;
    end else begin
      gnt = p1_req_valid_i;
    end
    // Ready is gated by reset so neither port sees an accept while held in reset.
    accept    = rst_n_i && (state == IDLE) && any_req;
    sel_wr    = gnt ? p1_req_wr_i    : p0_req_wr_i;
    sel_index = gnt ? p1_req_index_i : p0_req_index_i;
    sel_cmd   = gnt ? p1_req_cmd_i   : p0_req_cmd_i;
    sel_wdata = gnt ? p1_req_wdata_i : p0_req_wdata_i;
    sel_be    = gnt ? p1_req_be_i    : p0_req_be_i;
    // A write responds straight after its strobe. A read responds once the
    // wait counter has expired.
    rsp_fire  = ((state == ISSUE) && wr_q) || ((state == RD_WAIT) && (cnt == 4'd0));
    rsp_data  = (state == RD_WAIT) ? dev_rdata_i : 32'h0;
  end

  assign p0_req_ready_o = accept & ~gnt;
  assign p1_req_ready_o = accept & gnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state           <= IDLE;
      rr_last         <= 1'b1;
      gnt_q           <= 1'b0;
      wr_q            <= 1'b0;
      cnt             <= 4'd0;
      dev_index_o     <= 8'h0;
      dev_cmd_o       <= 8'h0;
      dev_wdata_o     <= 32'h0;
      dev_wvalid_be_o <= 4'h0;
      dev_wvalid_o    <= 1'b0;
      dev_rvalid_o    <= 1'b0;
      busy_o          <= 1'b0;
      p0_rsp_valid_o  <= 1'b0;
      p0_rsp_rdata_o  <= 32'h0;
      p1_rsp_valid_o  <= 1'b0;
      p1_rsp_rdata_o  <= 32'h0;
    end else begin
      // Strobes and response valids are single-cycle pulses.
      dev_wvalid_o   <= 1'b0;
      dev_rvalid_o   <= 1'b0;
      p0_rsp_valid_o <= 1'b0;
      p1_rsp_valid_o <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            dev_index_o     <= sel_index;
            dev_cmd_o       <= sel_cmd;
            dev_wdata_o     <= sel_wdata;
            dev_wvalid_be_o <= sel_be;
            dev_wvalid_o    <= sel_wr;
            dev_rvalid_o    <= ~sel_wr;
            gnt_q           <= gnt;
            wr_q            <= sel_wr;
            rr_last         <= gnt;
            busy_o          <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (wr_q) begin
            state <= RESP;
          end else begin
            cnt   <= CNT_LOAD;
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // The response lands in the RESP cycle. Only the granted port's rdata
      // register is updated; the other port keeps its previous value.
      if (rsp_fire) begin
        if (gnt_q) begin
          p1_rsp_valid_o <= 1'b1;
          p1_rsp_rdata_o <= rsp_data;
        end else begin
          p0_rsp_valid_o <= 1'b1;
          p0_rsp_rdata_o <= rsp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
`timescale 1ns/1ps
module tb_reg_bus_arbiter;
  localparam int NCFG = 3;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    int          due;
  } rsp_t;

  typedef struct {
    logic        wr;
    logic [51:0] f;
    int          due;
  } stb_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // The device read bus carries a different value in every cycle. A read
  // therefore returns exactly the value present in the cycle it sampled.
  function automatic logic [31:0] dmix(input int c);
    return 32'hDEADBEEF ^ (32'(c) * 32'h9E3779B1);
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int GI  = g;
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    localparam bit FP  = (g == 1);

    logic        rst_n;
    logic        vld [2];
    logic        wr  [2];
    logic [7:0]  idx [2];
    logic [7:0]  cmd [2];
    logic [31:0] wd  [2];
    logic [3:0]  be  [2];
    logic [31:0] dev_rd;
    logic        p0_rdy, p1_rdy, p0_rv, p1_rv;
    logic [31:0] p0_rd, p1_rd;
    logic [7:0]  dev_idx, dev_cmd;
    logic [31:0] dev_wd;
    logic [3:0]  dev_be;
    logic        dev_wv, dev_rv, busy;

    rsp_t        rq[$];
    stb_t        sq[$];
    int          zq[$];
    int          free_at = 0;
    int          rr = 1;
    int          busy_lo = 0;
    int          busy_hi = -1;
    int          acc = -1;
    int          obs = -1;
    logic [31:0] last_rd [2];
    logic [51:0] dev_hold;

    reg_bus_arbiter #(.RD_LAT(LAT), .FIXED_PRIO(FP)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .p0_req_valid_i(vld[0]), .p0_req_ready_o(p0_rdy), .p0_req_wr_i(wr[0]),
      .p0_req_index_i(idx[0]), .p0_req_cmd_i(cmd[0]), .p0_req_wdata_i(wd[0]),
      .p0_req_be_i(be[0]), .p0_rsp_valid_o(p0_rv), .p0_rsp_rdata_o(p0_rd),
      .p1_req_valid_i(vld[1]), .p1_req_ready_o(p1_rdy), .p1_req_wr_i(wr[1]),
      .p1_req_index_i(idx[1]), .p1_req_cmd_i(cmd[1]), .p1_req_wdata_i(wd[1]),
      .p1_req_be_i(be[1]), .p1_rsp_valid_o(p1_rv), .p1_rsp_rdata_o(p1_rd),
      .dev_index_o(dev_idx), .dev_cmd_o(dev_cmd), .dev_wdata_o(dev_wd),
      .dev_wvalid_be_o(dev_be), .dev_wvalid_o(dev_wv), .dev_rvalid_o(dev_rv),
      .dev_rdata_i(dev_rd), .busy_o(busy)
    );

    always @(negedge clk) dev_rd = dmix(cyc);

    function automatic string nm(input string s);
      return $sformatf("c%0d %s", GI, s);
    endfunction

    // Reference model: applied once per cycle to the inputs driven in that
    // cycle. It decides the grant from the arbitration rules, checks ready,
    // and queues the expected strobe and response.
    task automatic model_eval();
      int   c;
      int   gsel;
      rsp_t r;
      stb_t s;
      c    = cyc;
      gsel = -1;
      obs  = p0_rdy ? 0 : (p1_rdy ? 1 : -1);
      acc  = -1;
      if (!rst_n) begin
        chk(nm("ready_in_reset"), 128'({p1_rdy, p0_rdy}), 128'(0));
        rq.delete();
        sq.delete();
        rr      = 1;
        free_at = c + 1;
        busy_lo = 0;
        busy_hi = -1;
        zq.push_back(c + 1);
        return;
      end
      if (c >= free_at && (vld[0] || vld[1])) begin
        if (vld[0] && vld[1]) gsel = FP ? 0 : 1 - rr;
        else gsel = vld[0] ? 0 : 1;
      end
      chk(nm("ready"), 128'({p1_rdy, p0_rdy}), 128'({gsel == 1, gsel == 0}));
      if (gsel >= 0) begin
        s.wr  = wr[gsel];
        s.f   = {idx[gsel], cmd[gsel], wd[gsel], be[gsel]};
        s.due = c + 1;
        sq.push_back(s);
        r.port  = gsel;
        r.due   = wr[gsel] ? c + 2 : c + 2 + LAT;
        r.rdata = wr[gsel] ? 32'h0 : dmix(c + 1 + LAT);
        rq.push_back(r);
        free_at = r.due + 1;
        busy_lo = c + 1;
        busy_hi = r.due;
        rr      = gsel;
        acc     = gsel;
      end
    endtask

    task automatic step();
      #1;
      model_eval();
      @(negedge clk);
      #1;
    endtask

    // Monitor: checks the registered outputs of the current cycle against the queues.
    task automatic mon();
      int   c;
      rsp_t r;
      stb_t s;
      c = cyc;
      if (zq.size() != 0 && zq[0] == c) begin
        void'(zq.pop_front());
        chk(nm("dev_zero"), 128'({dev_idx, dev_cmd, dev_wd, dev_be, dev_wv, dev_rv, busy}), 128'(0));
        chk(nm("rsp_zero"), 128'({p0_rv, p0_rd, p1_rv, p1_rd}), 128'(0));
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        dev_hold   = 52'h0;
        return;
      end
      chk(nm("busy"), 128'(busy), 128'(c >= busy_lo && c <= busy_hi));
      if (dev_wv || dev_rv) begin
        if (sq.size() == 0) begin
          chk(nm("strobe_unexpected"), 128'({dev_wv, dev_rv}), 128'(0));
        end else begin
          s = sq.pop_front();
          chk(nm("strobe_kind"), 128'({dev_wv, dev_rv}), 128'({s.wr, !s.wr}));
          chk(nm("strobe_cycle"), 128'(c), 128'(s.due));
          dev_hold = s.f;
        end
      end else if (sq.size() != 0 && sq[0].due <= c) begin
        s = sq.pop_front();
        chk(nm("strobe_missing"), 128'({dev_wv, dev_rv}), 128'({s.wr, !s.wr}));
        dev_hold = s.f;
      end
      chk(nm("dev_fields"), 128'({dev_idx, dev_cmd, dev_wd, dev_be}), 128'(dev_hold));
      if (p0_rv || p1_rv) begin
        if (rq.size() == 0) begin
          chk(nm("rsp_unexpected"), 128'({p1_rv, p0_rv}), 128'(0));
        end else begin
          r = rq.pop_front();
          chk(nm("rsp_port"), 128'({p1_rv, p0_rv}), 128'(r.port == 1 ? 2'b10 : 2'b01));
          chk(nm("rsp_cycle"), 128'(c), 128'(r.due));
          last_rd[r.port] = r.rdata;
        end
      end else if (rq.size() != 0 && rq[0].due <= c) begin
        r = rq.pop_front();
        chk(nm("rsp_missing"), 128'({p1_rv, p0_rv}), 128'(r.port == 1 ? 2'b10 : 2'b01));
        last_rd[r.port] = r.rdata;
      end
      chk(nm("p0_rdata"), 128'(p0_rd), 128'(last_rd[0]));
      chk(nm("p1_rdata"), 128'(p1_rd), 128'(last_rd[1]));
    endtask

    always @(negedge clk) begin
      if (cyc >= 1) mon();
    end

    task automatic issue(input int p, input logic w, input logic [7:0] i, input logic [7:0] cm,
                         input logic [31:0] d, input logic [3:0] b);
      int n;
      n = 0;
      vld[p] = 1'b1; wr[p] = w; idx[p] = i; cmd[p] = cm; wd[p] = d; be[p] = b;
      vld[1 - p] = 1'b0;
      do begin
        step();
        n++;
      end while (acc != p && n < 100);
      if (acc != p) chk(nm("accept_timeout"), 128'(acc), 128'(p));
      vld[p] = 1'b0;
    endtask

    task automatic wait_idle();
      int n;
      n = 0;
      vld[0] = 1'b0;
      vld[1] = 1'b0;
      while (cyc < free_at && n < 100) begin
        step();
        n++;
      end
    endtask

    initial begin : drive
      int seq[$];
      int n;
      for (int p = 0; p < 2; p++) begin
        vld[p] = 1'b0; wr[p] = 1'b0; idx[p] = 8'h0; cmd[p] = 8'h0; wd[p] = 32'h0; be[p] = 4'h0;
      end
      // Reset is held with port 0 requesting; no ready may appear.
      rst_n  = 1'b0;
      vld[0] = 1'b1; wr[0] = 1'b1; idx[0] = 8'h55; cmd[0] = 8'hAA; wd[0] = 32'hCAFE0001; be[0] = 4'hF;
      repeat (5) step();
      rst_n = 1'b1;
      // Port 0 must be accepted in the first IDLE cycle after release.
      issue(0, 1'b1, 8'h55, 8'hAA, 32'hCAFE0001, 4'hF);
      wait_idle();
      issue(0, 1'b1, 8'h04, 8'h08, 32'h12153524, 4'b1011);
      wait_idle();
      issue(1, 1'b0, 8'h0C, 8'h04, 32'h0, 4'h0);
      wait_idle();

      // Contention: both ports keep requesting writes.
      seq.delete();
      n = 0;
      while (seq.size() < 4 && n < 200) begin
        for (int p = 0; p < 2; p++) begin
          vld[p] = 1'b1; wr[p] = 1'b1;
          idx[p] = 8'($urandom); cmd[p] = 8'($urandom); wd[p] = $urandom; be[p] = 4'($urandom);
        end
        step();
        if (obs >= 0) seq.push_back(obs);
        n++;
      end
      chk(nm("contention_count"), 128'(seq.size()), 128'(4));
      for (int k = 0; k < seq.size(); k++)
        chk(nm($sformatf("grant%0d", k)), 128'(seq[k]), 128'(FP ? 0 : k % 2));
      wait_idle();

      // Reset while a read is waiting on the device; the read is dropped.
      issue(0, 1'b0, 8'h21, 8'h10, 32'h0, 4'h0);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      issue(1, 1'b0, 8'h22, 8'h11, 32'h0, 4'h0);
      wait_idle();

      // Random traffic: valids toggle and fields change every cycle.
      for (int k = 0; k < 300; k++) begin
        for (int p = 0; p < 2; p++) begin
          vld[p] = ($urandom_range(0, 3) != 0);
          wr[p]  = 1'($urandom_range(0, 1));
          idx[p] = 8'($urandom); cmd[p] = 8'($urandom); wd[p] = $urandom; be[p] = 4'($urandom);
        end
        step();
      end
      wait_idle();
      repeat (3) step();
      chk(nm("drained"), 128'(rq.size() + sq.size()), 128'(0));
      done_cnt++;
    end
  end

  initial begin : finish_blk
    int n;
    n = 0;
    while (done_cnt < NCFG && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < NCFG) chk("global_timeout", 128'(done_cnt), 128'(NCFG));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Shares the single device register bus (dev_index/dev_cmd/dev_wdata/byte-enable/write strobe/read strobe/read data) between two requesters.
- Port 0 is the AXI4-Lite register bridge; port 1 is the local sensor/LCD init sequencer.
- Serialises one register transaction at a time, round-robin or fixed priority.
- Issues single-cycle strobes and returns write acks or read data to the winning port after a fixed device read latency.

Parameters:
- RD_LAT, 2, cycles from dev_rvalid_o strobe cycle to the cycle dev_rdata_i is valid; legal range 1..15.
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins when both request.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_n_i  in  1  synchronous reset, active-low.
- p0_req_valid_i  in  1  port 0 request valid; hold until accepted.
- p0_req_ready_o  out  1  port 0 request accepted this cycle.
- p0_req_wr_i  in  1  1 = write, 0 = read.
- p0_req_index_i  in  8  device index.
- p0_req_cmd_i  in  8  register/command number.
- p0_req_wdata_i  in  32  write data.
- p0_req_be_i  in  4  write byte enables.
- p0_rsp_valid_o  out  1  one-cycle response pulse (write ack or read data).
- p0_rsp_rdata_o  out  32  read data; 0 for write acks.
- p1_* (req_valid_i, req_ready_o, req_wr_i, req_index_i, req_cmd_i, req_wdata_i, req_be_i, rsp_valid_o, rsp_rdata_o)  same as port 0.
- dev_index_o  out  8  registered device index.
- dev_cmd_o  out  8  registered command.
- dev_wdata_o  out  32  registered write data.
- dev_wvalid_be_o  out  4  registered byte enables.
- dev_wvalid_o  out  1  one-cycle write strobe.
- dev_rvalid_o  out  1  one-cycle read strobe.
- dev_rdata_i  in  32  device read data.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Interface: one clock (clk_i); reset is synchronous and active-low (rst_n_i).
- Reset: state = IDLE; all outputs 0; rr_last = 1, so port 0 wins the first contention. No response is generated for a transaction in flight at reset; the transaction is dropped.
- States: IDLE, ISSUE, RD_WAIT, RESP.
- IDLE:
  - Grant is combinational from req_valid and rr_last.
  - Only port 0 valid -> grant 0. Only port 1 valid -> grant 1.
  - Both valid -> grant the port != rr_last (FIXED_PRIO=0) or port 0 (FIXED_PRIO=1).
  - pN_req_ready_o = 1 only for the granted port, only in IDLE; never both at once.
  - On accept: latch the request fields and grant id into dev_* registers; rr_last <= grant; go to ISSUE.
- ISSUE (1 cycle):
  - dev_wvalid_o = wr or dev_rvalid_o = !wr, for exactly this cycle.
  - dev_index_o / dev_cmd_o / dev_wdata_o / dev_wvalid_be_o are valid this cycle and hold their value until the next accept.
  - Write -> RESP. Read -> RD_WAIT, counter loaded with RD_LAT-1.
- RD_WAIT:
  - Decrement the counter; at 0, capture dev_rdata_i and go to RESP.
  - dev_rdata_i is sampled in cycle (strobe cycle + RD_LAT).
- RESP (1 cycle):
  - Granted port's rsp_valid_o = 1; rsp_rdata_o = captured data for reads, 0 for writes.
  - Other port's rsp_valid_o stays 0. Next state IDLE.
- Latency from accept cycle A:
  - Strobe in A+1.
  - Write rsp in A+2; read rsp in A+2+RD_LAT.
  - Next accept no earlier than rsp cycle + 1.
- Responses have no backpressure; the requester must take the pulse.
- rsp_rdata_o holds its value after the pulse until the next response on that port.
- Request field changes while valid is not accepted are ignored; only fields at the accept edge are used.
- A port dropping valid before accept is legal; no grant, no strobe.

Test Plan:
- Reset: hold rst_n_i=0 for 5 cycles with p0_req_valid_i=1 -> all outputs 0, no ready. Release -> p0_req_ready_o=1 in first IDLE cycle.
- P0 write: index 0x04, cmd 0x08, wdata 0x12153524, be 4'b1011 -> in A+1, dev_wvalid_o=1 with those values on dev_*; p0_rsp_valid_o=1 in A+2 with rdata 0; busy_o high A+1..A+2.
- P1 read, RD_LAT=2: index 0x0C, cmd 0x04; device drives 0xDEADBEEF only in strobe cycle +2 -> dev_rvalid_o pulse once; p1_rsp_valid_o at A+4 with 0xDEADBEEF; p0_rsp_valid_o stays 0.
- Contention, FIXED_PRIO=0: both ports hold valid with writes -> grants alternate 0,1,0,1 over 4 transactions. With FIXED_PRIO=1 -> four consecutive port-0 grants while port 0 stays valid.
- Mid-operation reset: assert rst_n_i=0 during RD_WAIT -> next cycle state IDLE, no rsp_valid on either port, dev_* = 0; a subsequent read completes normally.
- RD_LAT sweep (1, 15): read rsp arrives exactly at A+2+RD_LAT and carries the dev_rdata_i value present in strobe+RD_LAT; a different value is driven in the adjacent cycles to prove the sample point.
